// File: rtl/s3g_tx.sv
// S3G transmit framer: buffers a payload, then sends D5, length, payload, CRC8.
// Optional watchdog abort in wait phases is enabled with S3G_TX_TIMEOUT_EN.
module s3g_tx #(
  parameter int MAX_LEN = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       send,
  output logic [7:0] fill,
  output logic       busy,
  output logic       overflow,
  output logic       packet_sent,
  output logic       packet_error,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_done
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] LMAX = 8'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, START, LEN, DATA, CRC} state_t;
  typedef enum logic [1:0] {PH_ISSUE, PH_WAIT, PH_FIN} phase_t;

  state_t     r_state, w_state;
  phase_t     r_phase, w_phase;
  logic [7:0] r_fill, w_fill;
  logic [7:0] r_idx, w_idx;
  logic [7:0] r_crc, w_crc;
  logic       r_ovf, w_ovf;
  logic       r_sent, w_sent;
  logic [7:0] r_txd, w_txd;
  logic       r_txwr, w_txwr;
  logic [7:0] r_buf [MAX_LEN];
  logic       w_idle, w_full, w_wr_ok, w_go;
  logic [7:0] w_byte;

`ifdef S3G_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] r_tmo, w_tmo;
  logic          r_err, w_err;
`endif

  function automatic logic [7:0] nextCRC8_D8(
    input logic [7:0] d,
    input logic [7:0] c
  );
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
    return r;
  endfunction

  assign w_idle  = (r_state == IDLE);
  assign w_full  = (r_fill == LMAX);
  assign w_wr_ok = w_idle && wr_en && !w_full;
  assign w_go    = w_idle && send && (w_wr_ok || r_fill != 8'd0);
  assign w_byte  = r_buf[r_idx[AW-1:0]];

  always_comb begin
    w_state = r_state;
    w_phase = r_phase;
    w_fill  = r_fill;
    w_idx   = r_idx;
    w_crc   = r_crc;
    w_ovf   = r_ovf;
    w_sent  = 1'b0;
    w_txd   = r_txd;
    w_txwr  = 1'b0;
`ifdef S3G_TX_TIMEOUT_EN
    w_tmo   = '0;
    w_err   = 1'b0;
`endif
    if (wr_en && !w_wr_ok)
      w_ovf = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (w_wr_ok)
          w_fill = r_fill + 8'd1;
        if (w_go) begin
          w_state = START;
          w_phase = PH_ISSUE;
          w_idx   = 8'd0;
          w_ovf   = 1'b0;
        end
      end
      default: begin
        unique case (r_phase)
          PH_ISSUE: begin
            w_txwr  = 1'b1;
            w_phase = PH_WAIT;
            unique case (r_state)
              START: w_txd = 8'hD5;
              LEN:   w_txd = r_fill;
              DATA: begin
                w_txd = w_byte;
                w_crc = nextCRC8_D8(w_byte, r_crc);
                w_idx = r_idx + 8'd1;
              end
              default: w_txd = r_crc;
            endcase
          end
          PH_WAIT: begin
            if (tx_done) begin
              w_phase = PH_ISSUE;
              unique case (r_state)
                START: w_state = LEN;
                LEN:   w_state = DATA;
                DATA:  w_state = (r_idx == r_fill) ? CRC : DATA;
                default: w_phase = PH_FIN;
              endcase
            end
`ifdef S3G_TX_TIMEOUT_EN
            else if (r_tmo == TLAST) begin
              w_err   = 1'b1;
              w_state = IDLE;
              w_phase = PH_ISSUE;
              w_fill  = 8'd0;
              w_crc   = 8'd0;
            end else begin
              w_tmo = r_tmo + 1'b1;
            end
`endif
          end
          default: begin
            w_sent  = 1'b1;
            w_state = IDLE;
            w_phase = PH_ISSUE;
            w_fill  = 8'd0;
            w_crc   = 8'd0;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_phase <= PH_ISSUE;
      r_fill  <= 8'd0;
      r_idx   <= 8'd0;
      r_crc   <= 8'd0;
      r_ovf   <= 1'b0;
      r_sent  <= 1'b0;
      r_txd   <= 8'd0;
      r_txwr  <= 1'b0;
`ifdef S3G_TX_TIMEOUT_EN
      r_tmo   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_phase <= w_phase;
      r_fill  <= w_fill;
      r_idx   <= w_idx;
      r_crc   <= w_crc;
      r_ovf   <= w_ovf;
      r_sent  <= w_sent;
      r_txd   <= w_txd;
      r_txwr  <= w_txwr;
`ifdef S3G_TX_TIMEOUT_EN
      r_tmo   <= w_tmo;
      r_err   <= w_err;
`endif
    end
  end

  // Payload storage needs no reset: fill=0 makes old contents unreachable
  always_ff @(posedge clk) begin
    if (w_wr_ok)
      r_buf[r_fill[AW-1:0]] <= wr_data;
  end

  assign fill        = r_fill;
  assign busy        = !w_idle;
  assign overflow    = r_ovf;
  assign packet_sent = r_sent;
  assign tx_data     = r_txd;
  assign tx_wr       = r_txwr;
`ifdef S3G_TX_TIMEOUT_EN
  assign packet_error = r_err;
`else
  assign packet_error = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_s3g_tx.sv
// Self-checking bench for s3g_tx: UART responder model plus frame/CRC model.
// Runs with MAX_LEN=4, TIMEOUT=50; watchdog checks depend on S3G_TX_TIMEOUT_EN.
module tb_s3g_tx;
  localparam int ML = 4;
  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       send = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] fill;
  logic       busy;
  logic       overflow;
  logic       packet_sent;
  logic       packet_error;
  logic [7:0] tx_data;
  logic       tx_wr;

  s3g_tx #(.MAX_LEN(ML), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
    .send(send), .fill(fill), .busy(busy), .overflow(overflow),
    .packet_sent(packet_sent), .packet_error(packet_error),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] cap[$];
  int wr_cyc_q[$];
  logic [7:0] exp_q[$];
  int sent_n = 0, err_n = 0;
  int sent_cyc = 0, err_cyc = 0, done_cyc = 0;
  int withhold_at = 0;
  bit stray = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // UART responder: tx_done 10 cycles after each write strobe
  initial begin : uart
    int cd;
    cd = 0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (packet_sent) begin sent_n++; sent_cyc = cyc; end
      if (packet_error) begin err_n++; err_cyc = cyc; end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin tx_done = 1'b1; done_cyc = cyc; end
      end
      if (stray) begin tx_done = 1'b1; stray = 1'b0; end
      if (tx_wr) begin
        cap.push_back(tx_data);
        wr_cyc_q.push_back(cyc);
        if (cap.size() != withhold_at) cd = 10;
      end
    end
  end

  // Expected wire frame, CRC computed one bit at a time (LSB first)
  function automatic void model(input logic [7:0] p[$]);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    exp_q = {};
    exp_q.push_back(8'hD5);
    exp_q.push_back(8'(p.size()));
    foreach (p[i]) begin
      exp_q.push_back(p[i]);
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ p[i][b];
        c = c >> 1;
        if (fb) c = c ^ 8'h8C;
      end
    end
    exp_q.push_back(c);
  endfunction

  function automatic string hexs(input logic [7:0] q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] b);
    wr_data = b;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic fire();
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_sent(input int n0, output bit ok);
    for (int i = 0; i < 3000 && sent_n == n0; i++) @(negedge clk);
    ok = (sent_n != n0);
    tick(3);
  endtask

  task automatic clear_cap();
    cap = {};
    wr_cyc_q = {};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    checks++;
    if ({fill, busy, overflow, packet_sent, packet_error, tx_wr} !== 13'd0) begin
      errors++;
      $display("FAIL reset_ctl: got fill=%0d busy=%b ovf=%b ps=%b pe=%b wr=%b want all 0",
               fill, busy, overflow, packet_sent, packet_error, tx_wr);
    end
    checks++;
    if (tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_txdata: got %02h want 00", tx_data);
    end
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    int n0;
    bit ok;
    clear_cap();
    model('{8'h01});
    n0 = sent_n;
    put(8'h01);
    fire();
    wait_sent(n0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done: got no packet_sent want one"); end
    checks++;
    if (hexs(cap) != hexs(exp_q)) begin
      errors++;
      $display("FAIL single_frame: got %s want %s", hexs(cap), hexs(exp_q));
    end
    checks++;
    if (hexs(cap) != "d5 01 01 5e ") begin
      errors++;
      $display("FAIL single_lit: got %s want d5 01 01 5e", hexs(cap));
    end
    checks++;
    if (sent_n - n0 != 1) begin
      errors++;
      $display("FAIL single_pulses: got %0d want 1", sent_n - n0);
    end
    checks++;
    if (sent_cyc - done_cyc != 2) begin
      errors++;
      $display("FAIL single_lat: got %0d want 2 (negedge samples)", sent_cyc - done_cyc);
    end
    checks++;
    if (busy !== 1'b0 || fill !== 8'd0) begin
      errors++;
      $display("FAIL single_after: got busy=%b fill=%0d want 0 0", busy, fill);
    end
  endtask

  task automatic test_same_cycle();
    int n0, s;
    bit ok;
    clear_cap();
    model('{8'h00, 8'h00, 8'h00});
    n0 = sent_n;
    put(8'h00);
    put(8'h00);
    wr_data = 8'h00;
    wr_en = 1'b1;
    send = 1'b1;
    s = cyc;
    @(negedge clk);
    wr_en = 1'b0;
    send = 1'b0;
    wait_sent(n0, ok);
    checks++;
    if (!ok || hexs(cap) != hexs(exp_q)) begin
      errors++;
      $display("FAIL same_frame: got %s want %s", hexs(cap), hexs(exp_q));
    end
    checks++;
    if (wr_cyc_q.size() == 0 || wr_cyc_q[0] - s != 2) begin
      errors++;
      $display("FAIL same_first_wr: got %0d want 2",
               (wr_cyc_q.size() == 0) ? -1 : wr_cyc_q[0] - s);
    end
  endtask

  task automatic test_overflow();
    int n0;
    bit ok;
    clear_cap();
    model('{8'h10, 8'h11, 8'h12, 8'h13});
    for (int b = 'h10; b <= 'h14; b++) put(8'(b));
    tick(1);
    checks++;
    if (overflow !== 1'b1 || fill !== 8'd4) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b fill=%0d want 1 4", overflow, fill);
    end
    n0 = sent_n;
    fire();
    tick(1);
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%b busy=%b want 0 1", overflow, busy);
    end
    put(8'hAA);
    tick(1);
    checks++;
    if (overflow !== 1'b1 || fill !== 8'd4) begin
      errors++;
      $display("FAIL ovf_busy: got ovf=%b fill=%0d want 1 4", overflow, fill);
    end
    wait_sent(n0, ok);
    checks++;
    if (!ok || hexs(cap) != hexs(exp_q)) begin
      errors++;
      $display("FAIL ovf_frame: got %s want %s", hexs(cap), hexs(exp_q));
    end
  endtask

  task automatic test_empty_send();
    int n;
    bit saw_busy;
    clear_cap();
    saw_busy = 1'b0;
    fire();
    for (int i = 0; i < 100; i++) begin
      if (busy) saw_busy = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (cap.size() != 0 || saw_busy) begin
      errors++;
      $display("FAIL empty_send: got writes=%0d busy_seen=%b want 0 0", cap.size(), saw_busy);
    end
    n = sent_n;
    stray = 1'b1;
    tick(6);
    checks++;
    if (busy !== 1'b0 || fill !== 8'd0 || cap.size() != 0 || sent_n != n) begin
      errors++;
      $display("FAIL stray_done: got busy=%b fill=%0d writes=%0d want 0 0 0",
               busy, fill, cap.size());
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    bit ok;
    clear_cap();
    put(8'h21);
    put(8'h22);
    put(8'h23);
    fire();
    for (int i = 0; i < 500 && cap.size() < 3; i++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (tx_wr !== 1'b0 || busy !== 1'b0 || fill !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_state: got wr=%b busy=%b fill=%0d want 0 0 0", tx_wr, busy, fill);
    end
    tick(30);
    checks++;
    if (cap.size() != 3) begin
      errors++;
      $display("FAIL rstmid_writes: got %0d want 3", cap.size());
    end
    clear_cap();
    model('{8'h01});
    n0 = sent_n;
    put(8'h01);
    fire();
    wait_sent(n0, ok);
    checks++;
    if (!ok || hexs(cap) != hexs(exp_q)) begin
      errors++;
      $display("FAIL rstmid_frame: got %s want %s", hexs(cap), hexs(exp_q));
    end
  endtask

  task automatic test_random();
    logic [7:0] p[$];
    int len, n0;
    bit ok, same;
    for (int k = 0; k < 12; k++) begin
      clear_cap();
      p = {};
      len = $urandom_range(1, ML);
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      same = 1'($urandom_range(0, 1));
      model(p);
      n0 = sent_n;
      for (int i = 0; i < len - (same ? 1 : 0); i++) put(p[i]);
      if (same) begin
        wr_data = p[len-1];
        wr_en = 1'b1;
      end
      fire();
      wr_en = 1'b0;
      wait_sent(n0, ok);
      checks++;
      if (!ok || hexs(cap) != hexs(exp_q) || sent_n - n0 != 1) begin
        errors++;
        $display("FAIL rand_%0d: got %s want %s", k, hexs(cap), hexs(exp_q));
      end
      tick($urandom_range(0, 5));
    end
  endtask

  task automatic test_timeout();
    int e0, n0, lw;
    clear_cap();
    withhold_at = 2;
    e0 = err_n;
    n0 = sent_n;
    put(8'h5A);
    fire();
    for (int i = 0; i < 200 && cap.size() < 2; i++) @(negedge clk);
    lw = (wr_cyc_q.size() > 1) ? wr_cyc_q[1] : 0;
    tick(150);
`ifdef S3G_TX_TIMEOUT_EN
    checks++;
    if (err_n - e0 != 1) begin
      errors++;
      $display("FAIL tmo_pulses: got %0d want 1", err_n - e0);
    end
    checks++;
    if (err_cyc - lw != TO) begin
      errors++;
      $display("FAIL tmo_lat: got %0d want %0d", err_cyc - lw, TO);
    end
    checks++;
    if (busy !== 1'b0 || fill !== 8'd0 || sent_n != n0) begin
      errors++;
      $display("FAIL tmo_after: got busy=%b fill=%0d sent=%0d want 0 0 0",
               busy, fill, sent_n - n0);
    end
`else
    checks++;
    if (busy !== 1'b1 || err_n != e0 || sent_n != n0) begin
      errors++;
      $display("FAIL notmo_hold: got busy=%b err=%0d sent=%0d want 1 0 0",
               busy, err_n - e0, sent_n - n0);
    end
`endif
    withhold_at = 0;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_cycle();
    test_overflow();
    test_empty_send();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
